// File: rtl/proj_fm_ram_pkg.sv
// Package: proj_fm_ram_pkg
// Shared sizing helpers and types for the multi-channel feature-map RAM.
//   ch_bits()     : select width for a count of items (never narrower than 1)
//   addr_bits()   : address width for a power-of-2 depth (never narrower than 1)
//   clamp_shift() : saturate a requested repeat exponent to the supported max
//   fm_word_t     : default feature-map word
//   fm_ptr_t      : generic pointer container (wide enough for any plane/shift combo)
package proj_fm_ram_pkg;
  localparam int FM_DATA_BITS = 8;
  localparam int FM_PTR_BITS  = 16;

  typedef logic [FM_DATA_BITS-1:0] fm_word_t;
  typedef logic [FM_PTR_BITS-1:0]  fm_ptr_t;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int clamp_shift(input int s, input int mx);
    return (s > mx) ? mx : s;
  endfunction
endpackage

// File: rtl/proj_fm_ram_seq.sv
// Module: proj_fm_ram_seq
// Wrapping pointer sequencer: counts 0..limit then returns to 0.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart pointer at 0 (wins over adv)
//   adv        : advance by one
//   limit      : last value before wrap
//   ptr        : current pointer
//   wrap       : 1-cycle pulse the cycle after a wrap
module proj_fm_ram_seq #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] limit,
  output logic [W-1:0] ptr,
  output logic         wrap
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (adv) begin
      // >= rather than == so a limit that shrank under a live pointer still wraps
      if (ptr >= limit) begin
        ptr  <= '0;
        wrap <= 1'b1;
      end else begin
        ptr  <= ptr + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: rtl/proj_fm_ram_mc.sv
// Module: proj_fm_ram_mc
// Multi-channel feature-map RAM between projection and hash stages.
// CHANNELS planes of ENTRIES words, each with its own auto-incrementing write
// and read pointer. Reads replay each word 2^shift times (upsampled replay).
// Ports:
//   in_clk, in_rst_n          : clock, synchronous active-low reset
//   in_ptr_clr                : all pointers -> 0, memory untouched
//   in_rd_shift               : repeat exponent, captured while no read is in flight
//   in_wvalid/out_wready      : write handshake; in_wch, in_wdata
//   in_rreq/out_rreq_rdy      : read request handshake; in_rch
//   out_rvalid/in_rready      : read data handshake; out_rdata registered
//   out_wwrap                 : per-channel pulse after write pointer wraps
// Optional feature: define FM_RAM_CLEAR_EN to zero all planes after reset
// (ENTRIES cycles, both readies held low during the sweep).
module proj_fm_ram_mc
  import proj_fm_ram_pkg::*;
#(
  parameter int ENTRIES   = 32,
  parameter int DATA_BITS = FM_DATA_BITS,
  parameter int CHANNELS  = 4,
  parameter int SHIFT_MAX = 3,
  localparam int CH_BITS   = ch_bits(CHANNELS),
  localparam int ADDR_BITS = addr_bits(ENTRIES),
  localparam int SH_BITS   = ch_bits(SHIFT_MAX + 1),
  localparam int RP_BITS   = ADDR_BITS + SHIFT_MAX
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_ptr_clr,
  input  logic [SH_BITS-1:0]   in_rd_shift,
  input  logic                 in_wvalid,
  output logic                 out_wready,
  input  logic [CH_BITS-1:0]   in_wch,
  input  logic [DATA_BITS-1:0] in_wdata,
  input  logic                 in_rreq,
  output logic                 out_rreq_rdy,
  input  logic [CH_BITS-1:0]   in_rch,
  output logic                 out_rvalid,
  input  logic                 in_rready,
  output logic [DATA_BITS-1:0] out_rdata,
  output logic [CHANNELS-1:0]  out_wwrap
);
  logic ready;

`ifdef FM_RAM_CLEAR_EN
  logic                 clr_active;
  logic [ADDR_BITS-1:0] clr_addr;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      clr_active <= 1'b1;
      clr_addr   <= '0;
    end else if (clr_active) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == ADDR_BITS'(ENTRIES - 1)) clr_active <= 1'b0;
    end
  end

  assign ready = !clr_active;
`else
  assign ready = 1'b1;
`endif

  assign out_wready   = ready;
  assign out_rreq_rdy = ready & (!out_rvalid | in_rready);

  logic wch_ok, rch_ok, wr_acc, rd_acc;
  assign wch_ok = ({1'b0, in_wch} < (CH_BITS + 1)'(CHANNELS));
  assign rch_ok = ({1'b0, in_rch} < (CH_BITS + 1)'(CHANNELS));
  assign wr_acc = in_wvalid & out_wready;
  assign rd_acc = in_rreq & out_rreq_rdy;

  // Repeat exponent is frozen while a read is pending or being accepted
  logic [SH_BITS-1:0] sh_q;
  always_ff @(posedge in_clk) begin
    if (!in_rst_n)                   sh_q <= '0;
    else if (!out_rvalid && !rd_acc) sh_q <= SH_BITS'(clamp_shift(int'(in_rd_shift), SHIFT_MAX));
  end

  logic [RP_BITS-1:0] rlimit;
  assign rlimit = RP_BITS'((ENTRIES << sh_q) - 1);

  logic [CHANNELS-1:0][ADDR_BITS-1:0] wptr;
  logic [CHANNELS-1:0][RP_BITS-1:0]   rptr;
  logic [CHANNELS-1:0]                rwrap_unused;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    proj_fm_ram_seq #(.W(ADDR_BITS)) u_wseq (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .clr   (in_ptr_clr),
      .adv   (wr_acc & wch_ok & (in_wch == CH_BITS'(c))),
      .limit (ADDR_BITS'(ENTRIES - 1)),
      .ptr   (wptr[c]),
      .wrap  (out_wwrap[c])
    );
    proj_fm_ram_seq #(.W(RP_BITS)) u_rseq (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .clr   (in_ptr_clr),
      .adv   (rd_acc & rch_ok & (in_rch == CH_BITS'(c))),
      .limit (rlimit),
      .ptr   (rptr[c]),
      .wrap  (rwrap_unused[c])
    );
  end

  logic [ADDR_BITS-1:0] waddr, raddr;
  assign waddr = wptr[in_wch];
  assign raddr = ADDR_BITS'(rptr[in_rch] >> sh_q);

  // Storage: non-blocking write + separate read register gives read-before-write
  logic [DATA_BITS-1:0] mem [CHANNELS][ENTRIES];

  always_ff @(posedge in_clk) begin
`ifdef FM_RAM_CLEAR_EN
    if (clr_active) begin
      for (int c = 0; c < CHANNELS; c++) mem[c][clr_addr] <= '0;
    end else
`endif
    if (wr_acc && wch_ok) mem[in_wch][waddr] <= in_wdata;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      out_rvalid <= 1'b0;
      out_rdata  <= '0;
    end else if (rd_acc && rch_ok) begin
      out_rvalid <= 1'b1;
      out_rdata  <= mem[in_rch][raddr];
    end else if (in_rready) begin
      out_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_proj_fm_ram_mc.sv
// Bench for proj_fm_ram_mc: directed loops plus a vector table for the
// read-before-write / pointer-clear corner cases.
module tb_proj_fm_ram_mc;
  logic       in_clk = 1'b0;
  logic       in_rst_n, in_ptr_clr, in_wvalid, out_wready, in_rreq, out_rreq_rdy;
  logic       out_rvalid, in_rready;
  logic [1:0] in_rd_shift, in_wch, in_rch;
  logic [7:0] in_wdata, out_rdata;
  logic [3:0] out_wwrap;

  always #5 in_clk = ~in_clk;

  proj_fm_ram_mc dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_ptr_clr(in_ptr_clr),
    .in_rd_shift(in_rd_shift), .in_wvalid(in_wvalid), .out_wready(out_wready),
    .in_wch(in_wch), .in_wdata(in_wdata), .in_rreq(in_rreq),
    .out_rreq_rdy(out_rreq_rdy), .in_rch(in_rch), .out_rvalid(out_rvalid),
    .in_rready(in_rready), .out_rdata(out_rdata), .out_wwrap(out_wwrap)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle;
    in_ptr_clr = 1'b0; in_wvalid = 1'b0; in_rreq = 1'b0; in_rready = 1'b1;
  endtask

  typedef struct {
    logic       clr, wv;
    logic [1:0] wch;
    logic [7:0] wd;
    logic       rq;
    logic [1:0] rch;
    logic       rr;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic clr, logic wv, logic [7:0] wd, logic rq, logic rr,
                              logic ev, logic [7:0] ed);
    vec_t v;
    v.clr = clr; v.wv = wv; v.wch = 2'd2; v.wd = wd;
    v.rq = rq; v.rch = 2'd2; v.rr = rr; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    // Channel 2 vectors: concurrent write+read on the same address, then
    // a pointer clear that must keep the pending beat, then replay.
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, (k == 7) ? 8'h55 : 8'h10 + 8'(k), 1, 1, 1,
                       (k == 7) ? 8'hAA : 8'(k)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, (k == 7) ? 8'h55 : 8'h10 + 8'(k)));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00));

    idle();
    in_rd_shift = 2'd0; in_wch = 2'd0; in_rch = 2'd0; in_wdata = 8'h00;
    in_rst_n = 1'b0;
    tick(); tick();
    chk("rst_rvalid", {31'd0, out_rvalid}, 32'd0);
    chk("rst_rdata", {24'd0, out_rdata}, 32'd0);
    chk("rst_wwrap", {28'd0, out_wwrap}, 32'd0);
    in_rst_n = 1'b1;

`ifdef FM_RAM_CLEAR_EN
    begin
      int n;
      for (int i = 0; i < 10; i++) tick();
      in_rst_n = 1'b0;
      tick();
      in_rst_n = 1'b1;
      n = 0;
      while (!out_rreq_rdy && n < 100) begin tick(); n++; end
      chk("t6_sweep_len", n, 32'd32);
      chk("t6_wready", {31'd0, out_wready}, 32'd1);
      in_rreq = 1'b1; in_rready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        in_rch = 2'(c);
        for (int i = 0; i < 32; i++) begin
          tick();
          chk("t6_zero", {23'd0, out_rvalid, out_rdata}, 32'h100);
        end
      end
      idle();
      tick();
    end
`else
    tick();
    chk("rst_wready", {31'd0, out_wready}, 32'd1);
    chk("rst_rreq_rdy", {31'd0, out_rreq_rdy}, 32'd1);
`endif

    // Test 1: fill ch0, read back with shift 0
    in_wvalid = 1'b1; in_wch = 2'd0;
    for (int i = 0; i < 32; i++) begin
      in_wdata = 8'(i);
      tick();
      chk("t1_wwrap", {28'd0, out_wwrap}, (i == 31) ? 32'd1 : 32'd0);
    end
    idle();
    in_rd_shift = 2'd0;
    tick();
    in_rreq = 1'b1; in_rch = 2'd0;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("t1_read", {23'd0, out_rvalid, out_rdata}, 32'h100 | i);
    end
    idle();
    tick();
    chk("t1_drain", {31'd0, out_rvalid}, 32'd0);

    // Test 2: shift 2 replays each word four times, then wraps
    in_rd_shift = 2'd2;
    tick();
    in_rreq = 1'b1;
    for (int i = 0; i < 129; i++) begin
      tick();
      chk("t2_read", {23'd0, out_rvalid, out_rdata}, 32'h100 | ((i % 128) >> 2));
    end
    idle();
    tick();
    in_rd_shift = 2'd0;
    tick();

    // Test 3: ch1 write wrap pulse and 33rd write landing at address 0
    in_wvalid = 1'b1; in_wch = 2'd1;
    for (int i = 0; i < 33; i++) begin
      in_wdata = (i == 32) ? 8'hEE : 8'h40 + 8'(i);
      tick();
      chk("t3_wwrap", {28'd0, out_wwrap}, (i == 31) ? 32'd2 : 32'd0);
    end
    idle();
    in_rreq = 1'b1; in_rch = 2'd1;
    tick();
    chk("t3_addr0", {23'd0, out_rvalid, out_rdata}, 32'h1EE);

    // Test 4: back-pressure holds data and blocks new requests
    tick();
    chk("t4_first", {23'd0, out_rvalid, out_rdata}, 32'h141);
    in_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_rreq_rdy", {31'd0, out_rreq_rdy}, 32'd0);
      tick();
      chk("t4_hold", {23'd0, out_rvalid, out_rdata}, 32'h141);
    end
    in_rready = 1'b1;
    #1;
    chk("t4_rdy_back", {31'd0, out_rreq_rdy}, 32'd1);
    tick();
    chk("t4_next", {23'd0, out_rvalid, out_rdata}, 32'h142);
    idle();
    tick();
    chk("t4_drain", {31'd0, out_rvalid}, 32'd0);

    // Test 5: seed ch2 addr 0..7 (addr 7 = 0xAA), then table vectors
    in_wvalid = 1'b1; in_wch = 2'd2;
    for (int k = 0; k < 8; k++) begin
      in_wdata = (k == 7) ? 8'hAA : 8'(k);
      tick();
    end
    idle();
    foreach (tbl[j]) begin
      in_ptr_clr = tbl[j].clr; in_wvalid = tbl[j].wv; in_wch = tbl[j].wch;
      in_wdata = tbl[j].wd; in_rreq = tbl[j].rq; in_rch = tbl[j].rch;
      in_rready = tbl[j].rr;
      tick();
      chk($sformatf("t5_rvalid[%0d]", j), {31'd0, out_rvalid}, {31'd0, tbl[j].ev});
      if (tbl[j].ev) chk($sformatf("t5_rdata[%0d]", j), {24'd0, out_rdata}, {24'd0, tbl[j].ed});
    end
    idle();

    // Reset while a beat is held: valid and data are discarded
    in_rreq = 1'b1; in_rch = 2'd0;
    tick();
    chk("rst_mid_pre", {31'd0, out_rvalid}, 32'd1);
    in_rreq = 1'b0; in_rready = 1'b0; in_rst_n = 1'b0;
    tick();
    chk("rst_mid", {23'd0, out_rvalid, out_rdata}, 32'd0);
    in_rst_n = 1'b1; in_rready = 1'b1;
    tick();
    chk("rst_mid_after", {31'd0, out_rvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
